// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer: run/halt control, branch target selection and a
// saturating cycle counter. Define CALL_STACK_EN to build the call/return stack.
module pc_sequencer #(
  parameter int unsigned D  = 10,
  parameter int unsigned CW = 16,
  parameter int unsigned SD = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stall,
  input  logic          halt_in,
  input  logic          branch_en,
  input  logic          cond,
  input  logic          rel,
  input  logic [3:0]    lut_idx,
  input  logic          call,
  input  logic          ret,
  output logic [3:0]    lut_addr,
  input  logic [D-1:0]  target,
  output logic [D-1:0]  pc,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cycle_cnt,
  output logic          stk_err
);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e        state_q, state_d;
  logic [D-1:0]  pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, done_q;
  logic          taken;

  assign lut_addr = lut_idx;
  assign taken    = branch_en & cond;

`ifdef CALL_STACK_EN
  localparam int unsigned SpW  = $clog2(SD + 1);
  localparam int unsigned IdxW = (SD > 1) ? $clog2(SD) : 1;

  logic [SpW-1:0]  sp_q, sp_d;
  logic [D-1:0]    stack_q [SD];
  logic [IdxW-1:0] push_idx, pop_idx;
  logic            push_en;
  logic            err_q, err_d;

  assign push_idx = sp_q[IdxW-1:0];
  assign pop_idx  = push_idx - IdxW'(1);
  assign stk_err  = err_q;
`else
  logic unused_stack;
  assign unused_stack = call ^ ret ^ (SD == 0);
  assign stk_err      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
`ifdef CALL_STACK_EN
    sp_d    = sp_q;
    err_d   = err_q;
    push_en = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          pc_d    = '0;
        end
      end
      StRun: begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        if (stall) begin
          pc_d = pc_q;
        end else if (halt_in) begin
          state_d = StHalt;
`ifdef CALL_STACK_EN
        end else if (ret) begin
          // Returning from an empty stack falls through to the next instruction.
          if (sp_q == '0) begin
            pc_d  = pc_q + 1'b1;
            err_d = 1'b1;
          end else begin
            pc_d = stack_q[pop_idx];
            sp_d = sp_q - 1'b1;
          end
`endif
        end else if (taken) begin
          pc_d = rel ? pc_q + target : target;
`ifdef CALL_STACK_EN
          if (call) begin
            if (sp_q == SpW'(SD)) begin
              err_d = 1'b1;
            end else begin
              push_en = 1'b1;
              sp_d    = sp_q + 1'b1;
            end
          end
`endif
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      StHalt: begin
        if (start) begin
          state_d = StRun;
          pc_d    = '0;
          cnt_d   = '0;
`ifdef CALL_STACK_EN
          sp_d    = '0;
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CALL_STACK_EN
      sp_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == StRun);
      done_q  <= (state_d == StHalt);
`ifdef CALL_STACK_EN
      sp_q    <= sp_d;
      err_q   <= err_d;
`endif
    end
  end

`ifdef CALL_STACK_EN
  // Return storage needs no reset; sp_q defines which entries are valid.
  always_ff @(posedge clk) begin
    if (push_en) stack_q[push_idx] <= pc_q + 1'b1;
  end
`endif

  assign pc        = pc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; expectations follow CALL_STACK_EN when it is defined.
module tb_pc_sequencer;

  localparam int unsigned D  = 10;
  localparam int unsigned CW = 5;

  logic          clk = 1'b0;
  logic          reset, start, stall, halt_in, branch_en, cond, rel, call, ret;
  logic [3:0]    lut_idx, lut_addr;
  logic [D-1:0]  target, pc;
  logic          busy, done, stk_err;
  logic [CW-1:0] cycle_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.D(D), .CW(CW), .SD(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stall     (stall),
    .halt_in   (halt_in),
    .branch_en (branch_en),
    .cond      (cond),
    .rel       (rel),
    .lut_idx   (lut_idx),
    .call      (call),
    .ret       (ret),
    .lut_addr  (lut_addr),
    .target    (target),
    .pc        (pc),
    .busy      (busy),
    .done      (done),
    .cycle_cnt (cycle_cnt),
    .stk_err   (stk_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    start = 0; stall = 0; halt_in = 0; branch_en = 0; cond = 0; rel = 0;
    call = 0; ret = 0; lut_idx = 0; target = 0;
  endtask

  task automatic test_reset();
    clear();
    reset = 1;
    start = 1;
    step(); step();
    total_cnt++; if (pc !== 0) $display("FAIL reset_pc got %0d want 0", pc); else pass_cnt++;
    total_cnt++; if (busy !== 0) $display("FAIL reset_busy got %0b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 0) $display("FAIL reset_done got %0b want 0", done); else pass_cnt++;
    total_cnt++;
    if (cycle_cnt !== 0) $display("FAIL reset_cnt got %0d want 0", cycle_cnt); else pass_cnt++;
    total_cnt++;
    if (stk_err !== 0) $display("FAIL reset_err got %0b want 0", stk_err); else pass_cnt++;
    reset = 0;
    start = 0;
    step();
    total_cnt++; if (busy !== 0) $display("FAIL idle_busy got %0b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_start_run();
    start = 1;
    step();
    start = 0;
    total_cnt++; if (busy !== 1) $display("FAIL start_busy got %0b want 1", busy); else pass_cnt++;
    total_cnt++; if (pc !== 0) $display("FAIL start_pc got %0d want 0", pc); else pass_cnt++;
    repeat (5) step();
    total_cnt++; if (pc !== 5) $display("FAIL run5_pc got %0d want 5", pc); else pass_cnt++;
    total_cnt++;
    if (cycle_cnt !== 5) $display("FAIL run5_cnt got %0d want 5", cycle_cnt); else pass_cnt++;
  endtask

  task automatic test_wrap();
    branch_en = 1; cond = 1; rel = 0; target = 1022;
    step();
    clear();
    total_cnt++; if (pc !== 1022) $display("FAIL wrap_set got %0d want 1022", pc); else pass_cnt++;
    step();
    total_cnt++; if (pc !== 1023) $display("FAIL wrap_max got %0d want 1023", pc); else pass_cnt++;
    step();
    total_cnt++; if (pc !== 0) $display("FAIL wrap_zero got %0d want 0", pc); else pass_cnt++;
  endtask

  task automatic test_abs_branch();
    branch_en = 1; cond = 1; rel = 0; lut_idx = 2; target = 44;
    #1;
    total_cnt++;
    if (lut_addr !== 2) $display("FAIL lut_addr got %0d want 2", lut_addr); else pass_cnt++;
    step();
    total_cnt++; if (pc !== 44) $display("FAIL abs_taken got %0d want 44", pc); else pass_cnt++;
    cond = 0;
    step();
    total_cnt++; if (pc !== 45) $display("FAIL abs_not_taken got %0d want 45", pc); else pass_cnt++;
    clear();
    start = 1;
    step();
    start = 0;
    total_cnt++; if (pc !== 46) $display("FAIL start_in_run got %0d want 46", pc); else pass_cnt++;
  endtask

  task automatic test_rel_branch();
    branch_en = 1; cond = 1; rel = 0; target = 4;
    step();
    rel = 1; target = 1023;
    step();
    total_cnt++; if (pc !== 3) $display("FAIL rel_neg got %0d want 3", pc); else pass_cnt++;
    target = 20;
    step();
    clear();
    total_cnt++; if (pc !== 23) $display("FAIL rel_pos got %0d want 23", pc); else pass_cnt++;
  endtask

  task automatic test_stall_halt();
    stall = 1; halt_in = 1;
    step();
    total_cnt++; if (pc !== 23) $display("FAIL stall_pc got %0d want 23", pc); else pass_cnt++;
    total_cnt++; if (busy !== 1) $display("FAIL stall_busy got %0b want 1", busy); else pass_cnt++;
    total_cnt++;
    if (cycle_cnt !== 15) $display("FAIL stall_cnt got %0d want 15", cycle_cnt); else pass_cnt++;
    stall = 0;
    step();
    halt_in = 0;
    total_cnt++; if (done !== 1) $display("FAIL halt_done got %0b want 1", done); else pass_cnt++;
    total_cnt++; if (busy !== 0) $display("FAIL halt_busy got %0b want 0", busy); else pass_cnt++;
    repeat (3) step();
    total_cnt++; if (pc !== 23) $display("FAIL halt_pc got %0d want 23", pc); else pass_cnt++;
    total_cnt++;
    if (cycle_cnt !== 16) $display("FAIL halt_cnt got %0d want 16", cycle_cnt); else pass_cnt++;
    start = 1;
    step();
    start = 0;
    total_cnt++; if (pc !== 0) $display("FAIL restart_pc got %0d want 0", pc); else pass_cnt++;
    total_cnt++;
    if (cycle_cnt !== 0) $display("FAIL restart_cnt got %0d want 0", cycle_cnt); else pass_cnt++;
    total_cnt++; if (done !== 0) $display("FAIL restart_done got %0b want 0", done); else pass_cnt++;
    total_cnt++; if (busy !== 1) $display("FAIL restart_busy got %0b want 1", busy); else pass_cnt++;
  endtask

  task automatic test_stack();
    logic [D-1:0] exp_ret [5];
    logic [D-1:0] exp_first;
    logic         exp_err;
`ifdef CALL_STACK_EN
    exp_ret   = '{10'd301, 10'd201, 10'd101, 10'd12, 10'd13};
    exp_first = 11;
    exp_err   = 1;
`else
    exp_ret   = '{10'd501, 10'd502, 10'd503, 10'd504, 10'd505};
    exp_first = 91;
    exp_err   = 0;
`endif
    branch_en = 1; cond = 1; target = 10;
    step();
    call = 1; target = 90;
    step();
    total_cnt++; if (pc !== 90) $display("FAIL call_pc got %0d want 90", pc); else pass_cnt++;
    clear();
    ret = 1;
    step();
    ret = 0;
    total_cnt++;
    if (pc !== exp_first) $display("FAIL ret_pc got %0d want %0d", pc, exp_first); else pass_cnt++;
    for (int i = 1; i <= 5; i++) begin
      branch_en = 1; cond = 1; call = 1; target = D'(i * 100);
      step();
    end
    clear();
    total_cnt++; if (pc !== 500) $display("FAIL nest_pc got %0d want 500", pc); else pass_cnt++;
    total_cnt++;
    if (stk_err !== exp_err) $display("FAIL push_full_err got %0b want %0b", stk_err, exp_err);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      ret = 1;
      step();
      total_cnt++;
      if (pc !== exp_ret[i]) $display("FAIL pop%0d_pc got %0d want %0d", i, pc, exp_ret[i]);
      else pass_cnt++;
    end
    ret = 0;
    total_cnt++;
    if (stk_err !== exp_err) $display("FAIL pop_empty_err got %0b want %0b", stk_err, exp_err);
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    // 13 RUN edges since restart; 18 more reach 2^CW-1 = 31, the rest must stick.
    total_cnt++;
    if (cycle_cnt !== 13) $display("FAIL sat_pre got %0d want 13", cycle_cnt); else pass_cnt++;
    repeat (18) step();
    total_cnt++;
    if (cycle_cnt !== 31) $display("FAIL sat_max got %0d want 31", cycle_cnt); else pass_cnt++;
    repeat (4) step();
    total_cnt++;
    if (cycle_cnt !== 31) $display("FAIL sat_hold got %0d want 31", cycle_cnt); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_start_run();
    test_wrap();
    test_abs_branch();
    test_rel_branch();
    test_stall_halt();
    test_stack();
    test_saturate();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter and fetch sequencer for the core; owns the PC register and drives the branch-target LUT index.
- Each cycle it picks the next PC from four sources: hold, increment, absolute LUT target, or PC-relative LUT target.
- Provides run/halt control, a saturating cycle counter and an optional call/return stack.
- Sits between the decoder (branch, halt, stall controls) and the instruction memory address port.

Parameters:
- D, 10, PC and branch-target width in bits.
- CW, 16, cycle counter width.
- SD, 4, call stack depth (used only with CALL_STACK_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins or restarts execution.
- stall  in  1  hold PC this cycle.
- halt_in  in  1  decoded halt instruction.
- branch_en  in  1  current instruction is a branch.
- cond  in  1  branch condition (taken when 1).
- rel  in  1  1 = PC-relative target, 0 = absolute target.
- lut_idx  in  4  branch LUT index from the instruction.
- call  in  1  branch also pushes the return address.
- ret  in  1  return: pop the stack into PC.
- lut_addr  out  4  index to the branch-target LUT; combinational copy of lut_idx.
- target  in  D  LUT output. Unsigned for absolute branches; two's complement for relative branches.
- pc  out  D  current fetch address.
- busy  out  1  high in RUN.
- done  out  1  high in HALT.
- cycle_cnt  out  CW  count of RUN cycles (stalled cycles included).
- stk_err  out  1  sticky stack overflow/underflow flag.

Behaviour:
- Reset values: state IDLE, pc=0, busy=0, done=0, cycle_cnt=0, stk_err=0, stack pointer=0. Reset overrides every other input in the same cycle.
- IDLE: pc held at 0. start → RUN on the next edge; pc stays 0, so the first fetch is address 0.
- RUN, per-edge priority: stall > halt_in > ret > taken branch > increment.
  - stall: pc holds; no stack change; cycle_cnt still increments.
  - halt_in: → HALT; pc holds.
  - taken branch (branch_en & cond), absolute (rel=0): pc ← target.
  - taken branch, relative (rel=1): pc ← (pc + target) mod 2^D. Example: pc=4, target=2^D−1 gives pc=3.
  - otherwise: pc ← pc+1; 2^D−1 wraps to 0.
  - start in RUN is ignored.
  - branch_en with cond=0 behaves as increment.
- HALT: done=1, busy=0, pc and cycle_cnt frozen. start → RUN with pc=0, cycle_cnt=0, done=0, stack pointer=0, stk_err=0.
- cycle_cnt: +1 on each RUN edge; saturates at 2^CW−1.
- Latency: branch decision to new pc is 1 cycle. The LUT path is combinational: lut_idx → lut_addr → target in the same cycle.
- Outputs busy and done are registered, derived from state.

Optional Feature:
- Macro CALL_STACK_EN.
- Defined: SD-entry LIFO of D-bit return addresses.
  - call with a taken branch pushes pc+1, then branches.
  - ret pops into pc.
  - Push when full: push dropped, branch still taken, stk_err=1.
  - ret when empty: pc ← pc+1, stk_err=1.
  - call and ret in the same cycle: ret wins, no push.
  - Stall blocks both push and pop.
- Not defined: call is treated as a plain branch, ret is ignored (falls through to branch/increment priority), stk_err is tied 0, and no stack storage exists.

Test Plan:
- Reset, then pulse start → busy=1 next cycle, pc=0. 5 free-running cycles → pc=5, cycle_cnt=5.
- Force pc=1022 via an absolute branch (target=1022) and run 2 cycles → pc=1023, then 0 (wrap with D=10).
- Absolute branch: branch_en=1, cond=1, rel=0, lut_idx=2, target=44 → lut_addr=2 in the same cycle; pc=44 next cycle. Same stimulus with cond=0 → pc+1.
- Relative branch: pc=4, rel=1, target=1023 → pc=3. Then pc=3, target=20 → pc=23.
- stall=1 and halt_in=1 together → pc holds, still RUN. Release stall → HALT, done=1, pc frozen 3 cycles. start → pc=0, cycle_cnt=0, done=0.
- CALL_STACK_EN defined, SD=4: call at pc=10 to target 90 → pc=90; ret → pc=11. Five nested calls → 5th push dropped, stk_err=1. Five rets → 5th ret gives pc+1 and stk_err stays 1. Macro undefined: same sequence, ret → pc+1 and stk_err=0.
